// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the memory/write-back stage: FSM encoding and datapath width defaults.
package data_mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM: write on the rising edge, registered read (data valid one cycle after re).
// Never read and written in the same cycle by its owner; contents are not reset.
module data_ram
    import data_mem_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_stage.sv
// Memory/write-back stage: stores complete in one cycle, loads hold stall for READ_LAT cycles
// and write back in the following cycle; ALU results pass straight through with no latency.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              nClear,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write_in,
    input  logic [3:0]        dest_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        wb_dest,
    output logic              wb_en
);

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    mem_state_t        state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        dest_q;
    logic              m2r_q;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              is_load;
    logic              ram_we;
    logic              ram_re;

    assign addr    = alu_result[ADDR_W-1:0];
    assign is_load = mem_read & ~mem_write;

    // Stores only happen in IDLE, so the RAM port is never contended between read and write.
    assign ram_we   = nClear & (state == IDLE) & mem_write;
    assign ram_re   = nClear & (((state == IDLE) & is_load & (READ_LAT == 1)) |
                                ((state == RD_WAIT) & (cnt == 3'd1)));
    assign ram_addr = (state == RD_WAIT) ? addr_q : addr;

    data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .re      (ram_re),
        .addr    (ram_addr),
        .wr_data (store_data),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!nClear) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load) begin
                        cnt   <= LAT_M1;
                        state <= (READ_LAT == 1) ? RD_DONE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RD_DONE;
                    end
                end
                RD_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (nClear && state == IDLE && is_load) begin
            addr_q <= addr;
            dest_q <= dest_in;
            m2r_q  <= mem_to_reg;
        end
    end

    // Outputs are forced quiet while nClear is low so an aborted load never leaks a write-back.
    always_comb begin
        stall   = 1'b0;
        wb_data = alu_result;
        wb_dest = dest_in;
        wb_en   = 1'b0;
        if (nClear) begin
            case (state)
                IDLE: begin
                    if (is_load) begin
                        stall = 1'b1;
                    end else if (mem_write) begin
                        wb_en = reg_write_in & ~mem_to_reg & ~mem_read;
                    end else begin
                        wb_en = reg_write_in;
                    end
                end
                RD_WAIT: stall = 1'b1;
                RD_DONE: begin
                    wb_dest = dest_q;
                    wb_en   = reg_write_in;
                    if (m2r_q) begin
                        wb_data = ram_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: READ_LAT=2 and READ_LAT=1 builds against a transaction-level model.
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        nClear;
    logic        mem_read, mem_write, mem_to_reg, reg_write_in;
    logic [3:0]  dest_in;
    logic [15:0] alu_result, store_data;

    logic        stall0, stall1, en0, en1;
    logic [15:0] data0, data1;
    logic [3:0]  dst0, dst1;

    bit          sel;
    int          lat;
    int          n_vec = 0;
    int          n_bad = 0;

    logic [15:0] mem   [256];
    bit          known [256];

    logic        o_stall, o_en;
    logic [15:0] o_data;
    logic [3:0]  o_dst;

    always #5 clk = ~clk;

    assign o_stall = sel ? stall1 : stall0;
    assign o_en    = sel ? en1    : en0;
    assign o_data  = sel ? data1  : data0;
    assign o_dst   = sel ? dst1   : dst0;

    data_mem_stage #(.ADDR_W(8), .DATA_W(16), .READ_LAT(2)) dut (
        .clk(clk), .nClear(nClear), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write_in(reg_write_in), .dest_in(dest_in),
        .alu_result(alu_result), .store_data(store_data),
        .stall(stall0), .wb_data(data0), .wb_dest(dst0), .wb_en(en0)
    );

    data_mem_stage #(.ADDR_W(8), .DATA_W(16), .READ_LAT(1)) dut1 (
        .clk(clk), .nClear(nClear), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write_in(reg_write_in), .dest_in(dest_in),
        .alu_result(alu_result), .store_data(store_data),
        .stall(stall1), .wb_data(data1), .wb_dest(dst1), .wb_en(en1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (lat=%0d): got %0h expected %0h", tag, lat, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nClear    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall", 32'(o_stall), 0);
            chk("rst_wb_en", 32'(o_en), 0);
            step();
        end
        nClear = 1'b1;
    endtask

    // One upstream instruction: inputs held for as long as the stage stalls.
    task automatic op(input bit rd, input bit wr, input bit m2r, input bit rw,
                      input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] sd);
        int a;
        bit exp_en;
        a            = int'(alu[7:0]);
        mem_read     = rd;
        mem_write    = wr;
        mem_to_reg   = m2r;
        reg_write_in = rw;
        dest_in      = dst;
        alu_result   = alu;
        store_data   = sd;
        if (rd && !wr) begin
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                chk("ld_stall", 32'(o_stall), 1);
                chk("ld_wb_en", 32'(o_en), 0);
                step();
            end
            @(negedge clk);
            chk("wb_stall", 32'(o_stall), 0);
            chk("wb_en", 32'(o_en), 32'(rw));
            if (rw) begin
                chk("wb_dest", 32'(o_dst), 32'(dst));
                if (!m2r)
                    chk("wb_alu", 32'(o_data), 32'(alu));
                else if (known[a])
                    chk("wb_mem", 32'(o_data), 32'(mem[a]));
            end
        end else begin
            @(negedge clk);
            chk("op_stall", 32'(o_stall), 0);
            exp_en = wr ? (rw && !m2r && !rd) : rw;
            chk("op_wb_en", 32'(o_en), 32'(exp_en));
            if (exp_en) begin
                chk("op_dest", 32'(o_dst), 32'(dst));
                chk("op_data", 32'(o_data), 32'(alu));
            end
            if (wr) begin
                mem[a]   = sd;
                known[a] = 1'b1;
            end
        end
        step();
    endtask

    task automatic rand_ops(input int n);
        logic [15:0] alu;
        int r;
        repeat (n) begin
            r   = $urandom_range(0, 9);
            alu = 16'($urandom);
            alu[7:4] = 4'h0;
            op(r < 4 || r == 9, (r >= 4 && r < 7) || r == 9, 1'($urandom), 1'($urandom),
               4'($urandom), alu, 16'($urandom));
        end
    endtask

    initial begin
        nClear = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        reg_write_in = 1'b0; dest_in = 4'd0; alu_result = 16'd0; store_data = 16'd0;
        sel = 1'b0;
        lat = 2;
        foreach (known[i]) known[i] = 1'b0;
        #1;
        do_reset();

        op(0, 0, 0, 1, 4'd5, 16'h1234, 16'h0);
        op(0, 1, 0, 0, 4'd0, 16'h0010, 16'hBEEF);
        op(1, 0, 1, 1, 4'd7, 16'hFF10, 16'h0);
        chk("beef_model", 32'(mem[16]), 32'hBEEF);
        op(0, 1, 0, 0, 4'd0, 16'h0001, 16'hAAAA);
        op(0, 1, 0, 0, 4'd0, 16'h0002, 16'h5555);
        op(1, 0, 1, 1, 4'd1, 16'h0001, 16'h0);
        op(1, 0, 1, 1, 4'd2, 16'h0002, 16'h0);
        op(1, 1, 0, 1, 4'd3, 16'h0020, 16'h0F0F);
        op(1, 0, 1, 1, 4'd4, 16'h0020, 16'h0);

        // Abort a load in its wait cycle; the stage must come back idle with no write-back.
        mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; reg_write_in = 1'b1;
        dest_in = 4'd3; alu_result = 16'h0010;
        @(negedge clk);
        chk("abort_stall", 32'(o_stall), 1);
        step();
        do_reset();
        op(0, 0, 0, 1, 4'd9, 16'h7777, 16'h0);

        rand_ops(150);

        sel = 1'b1;
        lat = 1;
        foreach (known[i]) known[i] = 1'b0;
        do_reset();
        op(0, 1, 0, 0, 4'd0, 16'h0033, 16'hC0DE);
        op(1, 0, 1, 1, 4'd6, 16'h1233, 16'h0);
        op(1, 0, 1, 1, 4'd6, 16'h1233, 16'h0);
        op(1, 0, 0, 1, 4'd8, 16'h4321, 16'h0);
        rand_ops(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
Memory/write-back stage directly downstream of the single-cycle fetch/decode/register-file datapath.
- Consumes the ALU result, register data2 and the MemRead/MemWrite/MemToReg/RegWrite controls.
- Owns a synchronous-read data RAM and produces the write-back data, destination and enable for the register file.
- Multi-cycle loads stall the program counter through a stall handshake.

Parameters:
ADDR_W, 8, data RAM address width (depth 2^ADDR_W words)
DATA_W, 16, data word width
READ_LAT, 2, cycles the stall is held for a load (legal range 1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
nClear  input  1  synchronous active-low reset
mem_read  input  1  MemRead control for the current instruction
mem_write  input  1  MemWrite control for the current instruction
mem_to_reg  input  1  1 = write-back from RAM, 0 = write-back from ALU result
reg_write_in  input  1  RegWrite control for the current instruction
dest_in  input  4  destination register address
alu_result  input  DATA_W  ALU output, also the memory address
store_data  input  DATA_W  register data2, the store value
stall  output  1  1 = upstream must hold PC and all inputs stable
wb_data  output  DATA_W  write-back data to the register file
wb_dest  output  4  write-back register address
wb_en  output  1  register-file write enable

Behaviour:
- Clock and reset: one clock, clk. Reset is nClear, synchronous and active-low.
- Reset effects: while nClear=0 at a rising edge, FSM goes to IDLE and the wait counter goes to 0. stall=0 and wb_en=0 from that cycle on. RAM contents are not cleared.
- Addressing: address = alu_result[ADDR_W-1:0]. Upper bits are ignored, so the address wraps modulo 2^ADDR_W.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE, no memory op (mem_read=0, mem_write=0):
  - combinational pass-through: wb_data=alu_result, wb_dest=dest_in, wb_en=reg_write_in;
  - stall=0.
- IDLE, store (mem_write=1):
  - RAM[addr] <= store_data at the rising edge, single cycle, stall=0;
  - wb_en=reg_write_in & ~mem_to_reg.
- IDLE, load (mem_read=1, mem_write=0):
  - stall=1 combinationally in this cycle and wb_en=0;
  - at the edge: latch addr, dest_in and mem_to_reg; counter <= READ_LAT-1; go to RD_WAIT, or straight to RD_DONE if READ_LAT=1.
- RD_WAIT:
  - stall=1, wb_en=0;
  - counter decrements each cycle; when counter==1 the RAM read is issued, then go to RD_DONE.
- RD_DONE:
  - stall=0;
  - wb_data = latched mem_to_reg ? RAM read data : alu_result;
  - wb_dest = latched dest, wb_en = reg_write_in;
  - always returns to IDLE next edge. The mem_read still present this cycle is not re-triggered.
- Load timing: a load holds stall high for exactly READ_LAT cycles, and write-back occurs in cycle READ_LAT after acceptance.
- mem_read=1 and mem_write=1 together: the store wins, no read is performed, and wb_en=0.
- Back-to-back loads: the second load is accepted in the IDLE cycle following RD_DONE.
- Store then load to the same address: the load returns the newly stored value.
- Reset mid-read: the read is aborted, with no write-back and no stall in the cycle after the reset edge.
- Read-during-write on the RAM cannot occur, because stores are only accepted in IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RD_WAIT=2'd1, RD_DONE=2'd2) and DATA_W/ADDR_W defaults shared with the rest of the datapath.
- Sub-module data_ram: single-port synchronous RAM with write-enable and registered read, instantiated once. The FSM, counter and write-back mux live in data_mem_stage.

Test Plan:
- Reset: nClear=0 for 2 cycles during a load in RD_WAIT -> stall=0, wb_en=0, and no write-back is produced after release.
- ALU pass-through: alu_result=16'h1234, reg_write_in=1, dest_in=4'd5, no memory op -> same cycle wb_data=16'h1234, wb_dest=5, wb_en=1, stall=0.
- Store then load: store 16'hBEEF to address 8'h10, then load from alu_result=16'hFF10 (wrap) -> stall high for 2 cycles, then wb_data=16'hBEEF, wb_dest as given, wb_en=1.
- Back-to-back loads from addresses 8'h01 and 8'h02 holding 16'hAAAA and 16'h5555 -> two stall windows of READ_LAT cycles each, with write-backs in order.
- Simultaneous mem_read=1 and mem_write=1 with store_data=16'h0F0F at 8'h20 -> stall=0, wb_en=0; a following load of 8'h20 returns 16'h0F0F.
- READ_LAT=1 build: a load gives stall=1 for one cycle, then write-back in the next cycle.
